// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: frame-gap pacing, round-robin slot grant, level ramp.
// Define OBSTACLE_SCHED_STATS_EN to enable the saturating spawn counter.
module obstacle_scheduler #(
  parameter int N_SLOTS      = 3,
  parameter int GAP_BASE     = 90,
  parameter int GAP_STEP     = 10,
  parameter int GAP_FLOOR    = 30,
  parameter int LEVEL_FRAMES = 600,
  parameter int MAX_LEVEL    = 6,
  parameter int BIRD_LEVEL   = 2,
  parameter int SPAWN_THRESH = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               run_i,
  input  logic               hit_i,
  input  logic               next_frame_i,
  input  logic [15:0]        rand_i,
  input  logic [N_SLOTS-1:0] busy_i,
  output logic [N_SLOTS-1:0] spawn_o,
  output logic [2:0]         level_o,
  output logic [7:0]         spawn_cnt_o
);

  localparam int PW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int FW = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE, COOLDOWN, ARMED, FROZEN
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         gap_q, gap_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic [2:0]         level_q, level_d;
  logic [PW-1:0]      rr_q, rr_d, rr_next;
  logic [N_SLOTS-1:0] spawn_q, spawn_d;
  logic [N_SLOTS-1:0] elig, gnt_oh;
  logic [PW-1:0]      gnt_idx;
  logic               found, want, open, fire;
  int                 idx;
  logic               unused_rand;

  assign unused_rand = ^rand_i[15:8];

  function automatic logic [7:0] gap_of(input logic [2:0] lvl);
    int g;
    g = GAP_BASE - int'(lvl) * GAP_STEP;
    if (g < GAP_FLOOR) g = GAP_FLOOR;
    return 8'(g);
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_SLOTS; i++)
      elig[i] = !busy_i[i] &&
                (i == 0 || level_q >= 3'(BIRD_LEVEL));
  end

  // First eligible slot at or after rr_q, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    idx     = 0;
    for (int k = 0; k < N_SLOTS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_SLOTS) idx = idx - N_SLOTS;
      if (!found && elig[idx]) begin
        found   = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (found) gnt_oh[gnt_idx] = 1'b1;
  end

  assign rr_next = (gnt_idx == PW'(N_SLOTS - 1)) ?
                   '0 : gnt_idx + 1'b1;
  assign want = found && (rand_i[7:0] < 8'(SPAWN_THRESH));

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    frame_d = frame_q;
    level_d = level_q;
    rr_d    = rr_q;
    spawn_d = '0;
    fire    = 1'b0;
    open    = 1'b0;
    if (!run_i) begin
      state_d = IDLE;
      gap_d   = '0;
      frame_d = '0;
      level_d = '0;
      rr_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = COOLDOWN;
          gap_d   = gap_of(3'd0);
        end
        COOLDOWN, ARMED: begin
          if (hit_i) begin
            state_d = FROZEN;
          end else if (next_frame_i) begin
            if (frame_q == FW'(LEVEL_FRAMES - 1)) begin
              frame_d = '0;
              if (level_q < 3'(MAX_LEVEL))
                level_d = level_q + 3'd1;
            end else begin
              frame_d = frame_q + 1'b1;
            end
            // The frame that expires the gap is already a spawn opportunity.
            open = (state_q == ARMED) || (gap_q <= 8'd1);
            if (state_q == COOLDOWN && gap_q != 8'd0)
              gap_d = gap_q - 8'd1;
            if (open) begin
              if (want) begin
                state_d = COOLDOWN;
                gap_d   = gap_of(level_q);
                spawn_d = gnt_oh;
                rr_d    = rr_next;
                fire    = 1'b1;
              end else begin
                state_d = ARMED;
              end
            end
          end
        end
        FROZEN: begin
          if (!hit_i) begin
            state_d = COOLDOWN;
            gap_d   = gap_of(level_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gap_q   <= '0;
      frame_q <= '0;
      level_q <= '0;
      rr_q    <= '0;
      spawn_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
      level_q <= level_d;
      rr_q    <= rr_d;
      spawn_q <= spawn_d;
    end
  end

  assign spawn_o = spawn_q;
  assign level_o = level_q;

`ifdef OBSTACLE_SCHED_STATS_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else if (!run_i)
      cnt_q <= '0;
    else if (fire && cnt_q != 8'hFF)
      cnt_q <= cnt_q + 8'd1;
  end

  assign spawn_cnt_o = cnt_q;
`else
  logic unused_fire;
  assign unused_fire = fire;
  assign spawn_cnt_o = 8'd0;
`endif

endmodule
